// File: rtl/morra_match_tracker.sv
// ---------------------------------------------------------------------------
// morra_match_tracker
//   Follows the MorraCinese game FSMD from the outside: counts the rounds
//   won by each player in the current game, the game results of the match,
//   and declares a match winner once one player reaches WIN_GAMES game wins
//   or MAX_GAMES games have been played.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   START         in   start/restart a game (shared with the FSMD)
//   ROUND[1:0]    in   round result: 00 none, 01 P1, 10 P2, 11 invalid
//   GAME[1:0]     in   game result: 00 running, 01 P1, 10 P2, 11 draw
//   MATCH_CLEAR   in   clears a finished match (only honoured in MATCH_OVER)
//   P1_ROUNDS     out  P1 rounds in current game, saturating at 7
//   P2_ROUNDS     out  P2 rounds in current game, saturating at 7
//   P1_GAMES      out  P1 game wins this match
//   P2_GAMES      out  P2 game wins this match
//   DRAWS         out  drawn games this match
//   BUSY          out  high while a game is in progress
//   MATCH_OVER    out  high while the match result is held
//   MATCH_DONE    out  one-cycle pulse in the first MATCH_OVER cycle
//   MATCH_WINNER  out  00 none, 01 P1, 10 P2, 11 tie
// ---------------------------------------------------------------------------
module morra_match_tracker #(
  parameter int WIN_GAMES = 2,
  parameter int MAX_GAMES = 5,
  parameter int CW        = $clog2(MAX_GAMES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          START,
  input  logic [1:0]    ROUND,
  input  logic [1:0]    GAME,
  input  logic          MATCH_CLEAR,
  output logic [2:0]    P1_ROUNDS,
  output logic [2:0]    P2_ROUNDS,
  output logic [CW-1:0] P1_GAMES,
  output logic [CW-1:0] P2_GAMES,
  output logic [CW-1:0] DRAWS,
  output logic          BUSY,
  output logic          MATCH_OVER,
  output logic          MATCH_DONE,
  output logic [1:0]    MATCH_WINNER
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IN_GAME = 2'd1;
  localparam logic [1:0] S_OVER    = 2'd2;

  // Two extra bits so the three-counter sum can never wrap.
  localparam int            SW    = CW + 2;
  localparam logic [SW-1:0] WIN_C = SW'(WIN_GAMES);
  localparam logic [SW-1:0] MAX_C = SW'(MAX_GAMES);

  logic [1:0]    r_state;
  logic [2:0]    r_p1_rounds;
  logic [2:0]    r_p2_rounds;
  logic [CW-1:0] r_p1_games;
  logic [CW-1:0] r_p2_games;
  logic [CW-1:0] r_draws;
  logic          r_busy;
  logic          r_over;
  logic          r_done;
  logic [1:0]    r_winner;

  logic [1:0]    w_state_nxt;
  logic [2:0]    w_p1_rounds_nxt;
  logic [2:0]    w_p2_rounds_nxt;
  logic [CW-1:0] w_p1_games_nxt;
  logic [CW-1:0] w_p2_games_nxt;
  logic [CW-1:0] w_draws_nxt;
  logic [1:0]    w_winner_nxt;
  logic [SW-1:0] w_p1_ext;
  logic [SW-1:0] w_p2_ext;
  logic [SW-1:0] w_total;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Next-state and next-counter computation for all three states.
  always_comb begin
    w_state_nxt     = r_state;
    w_p1_rounds_nxt = r_p1_rounds;
    w_p2_rounds_nxt = r_p2_rounds;
    w_p1_games_nxt  = r_p1_games;
    w_p2_games_nxt  = r_p2_games;
    w_draws_nxt     = r_draws;
    w_winner_nxt    = r_winner;
    w_p1_ext        = {SW{1'b0}};
    w_p2_ext        = {SW{1'b0}};
    w_total         = {SW{1'b0}};

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nxt     = S_IN_GAME;
          w_p1_rounds_nxt = 3'd0;
          w_p2_rounds_nxt = 3'd0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_IN_GAME: begin
        if (START && (GAME == 2'b00)) begin
          // Restart of a running game: nothing recorded, rounds wiped.
          w_p1_rounds_nxt = 3'd0;
          w_p2_rounds_nxt = 3'd0;
        end else begin
          // The round of this cycle counts, including a final round.
          if (ROUND == 2'b01) begin
            w_p1_rounds_nxt = sat_inc3(r_p1_rounds);
          end else if (ROUND == 2'b10) begin
            w_p2_rounds_nxt = sat_inc3(r_p2_rounds);
          end else begin
            w_p1_rounds_nxt = r_p1_rounds;
          end

          if (GAME != 2'b00) begin
            case (GAME)
              2'b01:   w_p1_games_nxt = r_p1_games + CW'(1'b1);
              2'b10:   w_p2_games_nxt = r_p2_games + CW'(1'b1);
              default: w_draws_nxt    = r_draws + CW'(1'b1);
            endcase

            // Match decision is taken on the counts including this game.
            w_p1_ext = SW'(w_p1_games_nxt);
            w_p2_ext = SW'(w_p2_games_nxt);
            w_total  = w_p1_ext + w_p2_ext + SW'(w_draws_nxt);

            if (w_p1_ext == WIN_C) begin
              w_state_nxt  = S_OVER;
              w_winner_nxt = 2'b01;
            end else if (w_p2_ext == WIN_C) begin
              w_state_nxt  = S_OVER;
              w_winner_nxt = 2'b10;
            end else if (w_total == MAX_C) begin
              w_state_nxt = S_OVER;
              if (w_p1_ext > w_p2_ext) begin
                w_winner_nxt = 2'b01;
              end else if (w_p2_ext > w_p1_ext) begin
                w_winner_nxt = 2'b10;
              end else begin
                w_winner_nxt = 2'b11;
              end
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_state_nxt = S_IN_GAME;
          end
        end
      end

      S_OVER: begin
        if (MATCH_CLEAR) begin
          w_state_nxt     = S_IDLE;
          w_p1_rounds_nxt = 3'd0;
          w_p2_rounds_nxt = 3'd0;
          w_p1_games_nxt  = {CW{1'b0}};
          w_p2_games_nxt  = {CW{1'b0}};
          w_draws_nxt     = {CW{1'b0}};
          w_winner_nxt    = 2'b00;
        end else begin
          w_state_nxt = S_OVER;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a safe idle state.
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; flags are decoded from the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_p1_rounds <= 3'd0;
      r_p2_rounds <= 3'd0;
      r_p1_games  <= {CW{1'b0}};
      r_p2_games  <= {CW{1'b0}};
      r_draws     <= {CW{1'b0}};
      r_busy      <= 1'b0;
      r_over      <= 1'b0;
      r_done      <= 1'b0;
      r_winner    <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_p1_rounds <= w_p1_rounds_nxt;
      r_p2_rounds <= w_p2_rounds_nxt;
      r_p1_games  <= w_p1_games_nxt;
      r_p2_games  <= w_p2_games_nxt;
      r_draws     <= w_draws_nxt;
      r_busy      <= (w_state_nxt == S_IN_GAME);
      r_over      <= (w_state_nxt == S_OVER);
      r_done      <= (w_state_nxt == S_OVER) && (r_state != S_OVER);
      r_winner    <= w_winner_nxt;
    end
  end

  assign P1_ROUNDS    = r_p1_rounds;
  assign P2_ROUNDS    = r_p2_rounds;
  assign P1_GAMES     = r_p1_games;
  assign P2_GAMES     = r_p2_games;
  assign DRAWS        = r_draws;
  assign BUSY         = r_busy;
  assign MATCH_OVER   = r_over;
  assign MATCH_DONE   = r_done;
  assign MATCH_WINNER = r_winner;

endmodule

// File: tb/tb_morra_match_tracker.sv
// ---------------------------------------------------------------------------
// tb_morra_match_tracker
//   Directed stimulus against morra_match_tracker (WIN_GAMES=2, MAX_GAMES=5).
//   A behavioural match model predicts every output each cycle; literal
//   checks at key points pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_morra_match_tracker;

  localparam int WIN = 2;
  localparam int MAX = 5;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          START = 1'b0;
  logic [1:0]    ROUND = 2'b00;
  logic [1:0]    GAME = 2'b00;
  logic          MATCH_CLEAR = 1'b0;
  logic [2:0]    P1_ROUNDS;
  logic [2:0]    P2_ROUNDS;
  logic [CW-1:0] P1_GAMES;
  logic [CW-1:0] P2_GAMES;
  logic [CW-1:0] DRAWS;
  logic          BUSY;
  logic          MATCH_OVER;
  logic          MATCH_DONE;
  logic [1:0]    MATCH_WINNER;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  morra_match_tracker #(.WIN_GAMES(WIN), .MAX_GAMES(MAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .START        (START),
    .ROUND        (ROUND),
    .GAME         (GAME),
    .MATCH_CLEAR  (MATCH_CLEAR),
    .P1_ROUNDS    (P1_ROUNDS),
    .P2_ROUNDS    (P2_ROUNDS),
    .P1_GAMES     (P1_GAMES),
    .P2_GAMES     (P2_GAMES),
    .DRAWS        (DRAWS),
    .BUSY         (BUSY),
    .MATCH_OVER   (MATCH_OVER),
    .MATCH_DONE   (MATCH_DONE),
    .MATCH_WINNER (MATCH_WINNER)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Match model: phase 0 idle, 1 playing, 2 match finished.
  typedef struct packed {
    logic [1:0] phase;
    logic [7:0] p1r;
    logic [7:0] p2r;
    logic [7:0] g1;
    logic [7:0] g2;
    logic [7:0] dr;
    logic [1:0] win;
    logic       done;
  } model_t;

  model_t m = '0;

  function automatic model_t step_model(input model_t s, input logic st,
                                        input logic [1:0] rd, input logic [1:0] gm,
                                        input logic clr);
    model_t n;
    int total;
    n = s;
    n.done = 1'b0;
    if (s.phase == 2'd0) begin
      if (st) begin
        n.phase = 2'd1;
        n.p1r = 8'd0;
        n.p2r = 8'd0;
      end
    end else if (s.phase == 2'd1) begin
      if (st && gm == 2'b00) begin
        n.p1r = 8'd0;
        n.p2r = 8'd0;
      end else begin
        if (rd == 2'b01) n.p1r = (s.p1r >= 8'd7) ? 8'd7 : s.p1r + 8'd1;
        if (rd == 2'b10) n.p2r = (s.p2r >= 8'd7) ? 8'd7 : s.p2r + 8'd1;
        if (gm != 2'b00) begin
          if (gm == 2'b01) n.g1 = s.g1 + 8'd1;
          else if (gm == 2'b10) n.g2 = s.g2 + 8'd1;
          else n.dr = s.dr + 8'd1;
          total = int'(n.g1) + int'(n.g2) + int'(n.dr);
          n.phase = 2'd2;
          if (int'(n.g1) == WIN) n.win = 2'b01;
          else if (int'(n.g2) == WIN) n.win = 2'b10;
          else if (total == MAX) n.win = (n.g1 > n.g2) ? 2'b01 : ((n.g2 > n.g1) ? 2'b10 : 2'b11);
          else n.phase = 2'd0;
          n.done = (n.phase == 2'd2);
        end
      end
    end else begin
      if (clr) n = '0;
    end
    return n;
  endfunction

  // Model advances on the same edges as the DUT, including async reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else m <= step_model(m, START, ROUND, GAME, MATCH_CLEAR);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_P1_ROUNDS", 32'(P1_ROUNDS), 32'(m.p1r));
      chk("m_P2_ROUNDS", 32'(P2_ROUNDS), 32'(m.p2r));
      chk("m_P1_GAMES", 32'(P1_GAMES), 32'(m.g1));
      chk("m_P2_GAMES", 32'(P2_GAMES), 32'(m.g2));
      chk("m_DRAWS", 32'(DRAWS), 32'(m.dr));
      chk("m_BUSY", 32'(BUSY), 32'(m.phase == 2'd1));
      chk("m_MATCH_OVER", 32'(MATCH_OVER), 32'(m.phase == 2'd2));
      chk("m_MATCH_DONE", 32'(MATCH_DONE), 32'(m.done));
      chk("m_MATCH_WINNER", 32'(MATCH_WINNER), 32'(m.win));
    end
  end

  // One clock of stimulus; returns just after the following falling edge.
  task automatic drive(input logic st, input logic [1:0] rd, input logic [1:0] gm,
                       input logic clr);
    START = st;
    ROUND = rd;
    GAME = gm;
    MATCH_CLEAR = clr;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p1r"}, 32'(P1_ROUNDS), 32'd0);
    chk({tag, "_p2r"}, 32'(P2_ROUNDS), 32'd0);
    chk({tag, "_p1g"}, 32'(P1_GAMES), 32'd0);
    chk({tag, "_p2g"}, 32'(P2_GAMES), 32'd0);
    chk({tag, "_draws"}, 32'(DRAWS), 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_over"}, 32'(MATCH_OVER), 32'd0);
    chk({tag, "_done"}, 32'(MATCH_DONE), 32'd0);
    chk({tag, "_winner"}, 32'(MATCH_WINNER), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Two straight P1 games take the match.
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    chk("start_busy", 32'(BUSY), 32'd1);
    drive(1'b0, 2'b01, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 2'b01, 1'b0);
    chk("g1_p1r", 32'(P1_ROUNDS), 32'd2);
    chk("g1_p1g", 32'(P1_GAMES), 32'd1);
    chk("g1_busy", 32'(BUSY), 32'd0);
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b01, 1'b0);
    chk("win_p1r", 32'(P1_ROUNDS), 32'd1);
    chk("win_p1g", 32'(P1_GAMES), 32'd2);
    chk("win_done", 32'(MATCH_DONE), 32'd1);
    chk("win_over", 32'(MATCH_OVER), 32'd1);
    chk("win_winner", 32'(MATCH_WINNER), 32'd1);

    // Inputs ignored while the result is held, then cleared.
    drive(1'b1, 2'b00, 2'b01, 1'b0);
    chk("held_p1g", 32'(P1_GAMES), 32'd2);
    chk("held_done", 32'(MATCH_DONE), 32'd0);
    chk("held_over", 32'(MATCH_OVER), 32'd1);
    drive(1'b0, 2'b00, 2'b00, 1'b1);
    chk_all_zero("clear");

    // START held two cycles, then a P2 game.
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b0, 2'b10, 2'b00, 1'b0);
    drive(1'b0, 2'b10, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b10, 1'b0);
    chk("p2g_p1r", 32'(P1_ROUNDS), 32'd1);
    chk("p2g_p2r", 32'(P2_ROUNDS), 32'd2);
    chk("p2g_p2g", 32'(P2_GAMES), 32'd1);
    chk("p2g_busy", 32'(BUSY), 32'd0);

    // GAME outside a game is ignored.
    drive(1'b0, 2'b00, 2'b01, 1'b0);
    chk("idle_game_p1g", 32'(P1_GAMES), 32'd0);

    // Restart mid-game.
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b00, 1'b0);
    drive(1'b0, 2'b01, 2'b00, 1'b0);
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    chk("restart_p1r", 32'(P1_ROUNDS), 32'd0);
    chk("restart_busy", 32'(BUSY), 32'd1);
    chk("restart_p2g", 32'(P2_GAMES), 32'd1);
    drive(1'b1, 2'b01, 2'b00, 1'b0);
    chk("restart_hold_p1r", 32'(P1_ROUNDS), 32'd0);
    drive(1'b0, 2'b00, 2'b11, 1'b0);
    chk("draw1", 32'(DRAWS), 32'd1);

    // Reach MAX_GAMES with P1=1, P2=1, draws=3 -> tie.
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 2'b01, 1'b0);
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 2'b11, 1'b0);
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b0, 2'b10, 2'b11, 1'b0);
    chk("tie_draws", 32'(DRAWS), 32'd3);
    chk("tie_winner", 32'(MATCH_WINNER), 32'd3);
    chk("tie_done", 32'(MATCH_DONE), 32'd1);
    chk("tie_p2r", 32'(P2_ROUNDS), 32'd1);
    drive(1'b0, 2'b00, 2'b00, 1'b1);

    // START together with GAME: the result wins, START acts next cycle.
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 2'b10, 2'b01, 1'b0);
    chk("prio_p1g", 32'(P1_GAMES), 32'd1);
    chk("prio_p2r", 32'(P2_ROUNDS), 32'd1);
    chk("prio_busy", 32'(BUSY), 32'd0);
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    chk("prio_next_busy", 32'(BUSY), 32'd1);
    chk("prio_next_p2r", 32'(P2_ROUNDS), 32'd0);

    // Round counter saturation.
    for (int i = 0; i < 9; i++) drive(1'b0, 2'b01, 2'b00, 1'b0);
    chk("sat_p1r", 32'(P1_ROUNDS), 32'd7);

    // Asynchronous reset in the middle of a match.
    START = 1'b0;
    ROUND = 2'b00;
    #3 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 2'b00, 1'b0);
    chk("post_rst_busy", 32'(BUSY), 32'd0);

    // MAX_GAMES with P1 majority: P1 then four draws.
    drive(1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b0, 2'b00, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 2'b00, 1'b0);
      drive(1'b0, 2'b00, 2'b11, 1'b0);
    end
    chk("maj_winner", 32'(MATCH_WINNER), 32'd1);
    chk("maj_draws", 32'(DRAWS), 32'd4);
    chk("maj_over", 32'(MATCH_OVER), 32'd1);
    drive(1'b0, 2'b00, 2'b00, 1'b0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
